// File: rtl/sp_unit_if.sv
// Stack-pointer unit bus: operation request in, pointer and status out.
interface sp_unit_if #(
  parameter int W = 8
);
  logic [2:0]   ctrl;
  logic [W-1:0] din;
  logic [W-1:0] sp;
  logic         ovf;
  logic         udf;
  logic         fault;
  logic         at_lo;
  logic         at_hi;

  modport master (
    output ctrl, din,
    input  sp, ovf, udf, fault, at_lo, at_hi
  );

  modport slave (
    input  ctrl, din,
    output sp, ovf, udf, fault, at_lo, at_hi
  );
endinterface

// File: rtl/sp_unit.sv
// Bounded stack pointer updated on the falling clock edge; any out-of-range
// request freezes the pointer in FAULT until an explicit clear.
module sp_unit #(
  parameter int W         = 8,
  parameter int RESET_VAL = 128,
  parameter int LIMIT_LO  = 0,
  parameter int LIMIT_HI  = (1 << W) - 1,
  parameter int STEP      = 1
) (
  input logic     clk,
  input logic     rst_n,
  sp_unit_if.slave bus
);

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FAULT = 1'b1
  } state_t;

  localparam logic [2:0] OP_CLEAR = 3'b001;
  localparam logic [2:0] OP_INC   = 3'b010;
  localparam logic [2:0] OP_DEC   = 3'b011;
  localparam logic [2:0] OP_LOAD  = 3'b100;
  localparam logic [2:0] OP_ADD   = 3'b101;

  // Two guard bits keep every candidate exact, so range checks never see a wrap.
  localparam logic signed [W+1:0] LO_C   = (W+2)'(LIMIT_LO);
  localparam logic signed [W+1:0] HI_C   = (W+2)'(LIMIT_HI);
  localparam logic signed [W+1:0] STEP_C = (W+2)'(STEP);
  localparam logic [W-1:0]        LO_W   = W'(LIMIT_LO);
  localparam logic [W-1:0]        HI_W   = W'(LIMIT_HI);
  localparam logic [W-1:0]        RST_W  = W'(RESET_VAL);

  if ((LIMIT_LO > RESET_VAL) || (RESET_VAL > LIMIT_HI) ||
      (STEP < 1) || (STEP > (LIMIT_HI - LIMIT_LO))) begin : g_bad_params
    $error("sp_unit: illegal RESET_VAL/LIMIT_LO/LIMIT_HI/STEP combination");
  end

  state_t              state_r, state_nx_s;
  logic [W-1:0]        sp_r, sp_nx_s;
  logic                ovf_r, ovf_nx_s;
  logic                udf_r, udf_nx_s;
  logic signed [W+1:0] cur_s;
  logic signed [W+1:0] cand_s;
  logic                upd_s;

  assign cur_s = $signed({2'b00, sp_r});

  // State register and flags, updated on the falling edge.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= RUN;
      sp_r    <= RST_W;
      ovf_r   <= 1'b0;
      udf_r   <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      sp_r    <= sp_nx_s;
      ovf_r   <= ovf_nx_s;
      udf_r   <= udf_nx_s;
    end
  end

  // Candidate computation, range check and next-state selection.
  always_comb begin
    state_nx_s = state_r;
    sp_nx_s    = sp_r;
    ovf_nx_s   = ovf_r;
    udf_nx_s   = udf_r;
    cand_s     = cur_s;
    upd_s      = 1'b0;

    case (state_r)
      RUN: begin
        case (bus.ctrl)
          OP_INC: begin
            cand_s = cur_s + STEP_C;
            upd_s  = 1'b1;
          end
          OP_DEC: begin
            cand_s = cur_s - STEP_C;
            upd_s  = 1'b1;
          end
          OP_LOAD: begin
            cand_s = $signed({2'b00, bus.din});
            upd_s  = 1'b1;
          end
          OP_ADD: begin
            cand_s = cur_s + $signed({{2{bus.din[W-1]}}, bus.din});
            upd_s  = 1'b1;
          end
          default: begin
            cand_s = cur_s;
            upd_s  = 1'b0;
          end
        endcase
      end
      FAULT: begin
        upd_s = 1'b0;
      end
      default: begin
        upd_s = 1'b0;
      end
    endcase

    if (bus.ctrl == OP_CLEAR) begin
      state_nx_s = RUN;
      sp_nx_s    = RST_W;
      ovf_nx_s   = 1'b0;
      udf_nx_s   = 1'b0;
    end else if (upd_s) begin
      if (cand_s > HI_C) begin
        state_nx_s = FAULT;
        ovf_nx_s   = 1'b1;
      end else if (cand_s < LO_C) begin
        state_nx_s = FAULT;
        udf_nx_s   = 1'b1;
      end else begin
        sp_nx_s = cand_s[W-1:0];
      end
    end else begin
      state_nx_s = state_r;
    end
  end

  assign bus.sp    = sp_r;
  assign bus.ovf   = ovf_r;
  assign bus.udf   = udf_r;
  assign bus.fault = (state_r == FAULT);
  assign bus.at_lo = (sp_r == LO_W);
  assign bus.at_hi = (sp_r == HI_W);

endmodule

// File: tb/tb_sp_unit.sv
// Directed bench for sp_unit: three instances share one stimulus stream and
// are compared every cycle against an integer model, plus literal spot checks.
module tb_sp_unit;

  typedef struct {
    int sp;
    bit ovf;
    bit udf;
    bit flt;
  } mstate_t;

  logic       clk = 1'b1;
  logic       rst_n;
  logic [2:0] ctrl_v;
  logic [7:0] din_v;
  bit         check_en = 1'b0;
  int         n_tests = 0;
  int         n_fail  = 0;

  int      m_hi[3]   = '{255, 130, 132};
  int      m_step[3] = '{1, 4, 4};
  mstate_t m[3];

  sp_unit_if #(.W(8)) if0 ();
  sp_unit_if #(.W(8)) if1 ();
  sp_unit_if #(.W(8)) if2 ();

  assign if0.ctrl = ctrl_v;  assign if0.din = din_v;
  assign if1.ctrl = ctrl_v;  assign if1.din = din_v;
  assign if2.ctrl = ctrl_v;  assign if2.din = din_v;

  sp_unit #(.W(8)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
  sp_unit #(.W(8), .LIMIT_HI(130), .STEP(4)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
  sp_unit #(.W(8), .LIMIT_HI(132), .STEP(4)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));

  logic [7:0] d_sp[3];
  logic [2:0] d_ovf, d_udf, d_flt, d_lo, d_hi;
  assign d_sp[0] = if0.sp;  assign d_sp[1] = if1.sp;  assign d_sp[2] = if2.sp;
  assign d_ovf = {if2.ovf, if1.ovf, if0.ovf};
  assign d_udf = {if2.udf, if1.udf, if0.udf};
  assign d_flt = {if2.fault, if1.fault, if0.fault};
  assign d_lo  = {if2.at_lo, if1.at_lo, if0.at_lo};
  assign d_hi  = {if2.at_hi, if1.at_hi, if0.at_hi};

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic mstate_t reset_state();
    mstate_t s;
    s.sp = 128; s.ovf = 1'b0; s.udf = 1'b0; s.flt = 1'b0;
    return s;
  endfunction

  // Reference behaviour in plain integer arithmetic.
  function automatic mstate_t model_next(mstate_t s, int op, int din, int hi, int step);
    mstate_t n = s;
    int c;
    bit upd = 1'b1;
    if (op == 1) return reset_state();
    if (s.flt) return s;
    case (op)
      2: c = s.sp + step;
      3: c = s.sp - step;
      4: c = din;
      5: c = s.sp + ((din >= 128) ? din - 256 : din);
      default: begin c = s.sp; upd = 1'b0; end
    endcase
    if (upd) begin
      if (c > hi) begin n.ovf = 1'b1; n.flt = 1'b1; end
      else if (c < 0) begin n.udf = 1'b1; n.flt = 1'b1; end
      else n.sp = c;
    end
    return n;
  endfunction

  always @(negedge clk or negedge rst_n) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) m[i] <= reset_state();
      else m[i] <= model_next(m[i], int'(ctrl_v), int'(din_v), m_hi[i], m_step[i]);
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(posedge clk) begin
    if (check_en) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("cmp%0d.sp", i),    int'(d_sp[i]),  m[i].sp);
        chk($sformatf("cmp%0d.ovf", i),   int'(d_ovf[i]), int'(m[i].ovf));
        chk($sformatf("cmp%0d.udf", i),   int'(d_udf[i]), int'(m[i].udf));
        chk($sformatf("cmp%0d.fault", i), int'(d_flt[i]), int'(m[i].flt));
        chk($sformatf("cmp%0d.at_lo", i), int'(d_lo[i]),  int'(m[i].sp == 0));
        chk($sformatf("cmp%0d.at_hi", i), int'(d_hi[i]),  int'(m[i].sp == m_hi[i]));
      end
    end
  end

  task automatic step(input logic [2:0] op, input logic [7:0] d);
    @(posedge clk);
    ctrl_v = op;
    din_v  = d;
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst_n  = 1'b0;
    ctrl_v = 3'b000;
    din_v  = 8'h00;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
    chk("reset.sp", int'(if0.sp), 128);
    chk("reset.ovf", int'(if0.ovf), 0);
    chk("reset.fault", int'(if0.fault), 0);
    check_en = 1'b1;

    step(3'b010, 8'h00); chk("inc1.sp", int'(if0.sp), 129);
    step(3'b010, 8'h00); chk("inc2.sp", int'(if0.sp), 130);
    step(3'b010, 8'h00); chk("inc3.sp", int'(if0.sp), 131);
    chk("inc3.at_lo", int'(if0.at_lo), 0);
    chk("inc3.at_hi", int'(if0.at_hi), 0);
    step(3'b110, 8'h00); chk("rsvd.sp", int'(if0.sp), 131);
    step(3'b101, 8'h05); chk("addpos.sp", int'(if0.sp), 136);

    step(3'b100, 8'hFF); chk("load255.sp", int'(if0.sp), 255);
    step(3'b010, 8'h00);
    chk("ovf.sp", int'(if0.sp), 255);
    chk("ovf.ovf", int'(if0.ovf), 1);
    chk("ovf.fault", int'(if0.fault), 1);
    chk("ovf.at_hi", int'(if0.at_hi), 1);
    step(3'b011, 8'h00); chk("fault_dec.sp", int'(if0.sp), 255);

    step(3'b001, 8'h00);
    chk("clear.sp", int'(if0.sp), 128);
    chk("clear.ovf", int'(if0.ovf), 0);
    chk("clear.fault", int'(if0.fault), 0);
    step(3'b011, 8'h00); chk("dec.sp", int'(if0.sp), 127);

    step(3'b100, 8'h02);
    step(3'b101, 8'hFD);
    chk("udf.sp", int'(if0.sp), 2);
    chk("udf.udf", int'(if0.udf), 1);
    chk("udf.ovf", int'(if0.ovf), 0);
    step(3'b001, 8'h00);
    step(3'b100, 8'h03);
    step(3'b101, 8'hFD);
    chk("add0.sp", int'(if0.sp), 0);
    chk("add0.at_lo", int'(if0.at_lo), 1);
    chk("add0.udf", int'(if0.udf), 0);

    step(3'b001, 8'h00);
    step(3'b010, 8'h00);
    chk("step4_hi130.sp", int'(if1.sp), 128);
    chk("step4_hi130.ovf", int'(if1.ovf), 1);
    chk("step4_hi132.sp", int'(if2.sp), 132);
    chk("step4_hi132.ovf", int'(if2.ovf), 0);
    chk("step4_hi132.at_hi", int'(if2.at_hi), 1);

    step(3'b100, 8'hFF);
    step(3'b010, 8'h00);
    chk("pre_rst.fault", int'(if0.fault), 1);
    @(posedge clk);
    ctrl_v = 3'b000;
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst.sp", int'(if0.sp), 128);
    chk("async_rst.ovf", int'(if0.ovf), 0);
    chk("async_rst.fault", int'(if0.fault), 0);
    chk("async_rst.u1_ovf", int'(if1.ovf), 0);
    @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    step(3'b010, 8'h00); chk("post_rst_inc.sp", int'(if0.sp), 129);
    step(3'b000, 8'h00);
    @(posedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sp_unit.md
SP_UNIT -- requirements
Module: sp_unit

Interface
REQ-001 The block SHALL take parameter W, default 8, as the stack pointer width in bits.
REQ-002 The block SHALL take parameter RESET_VAL, default 128, as the pointer value after reset or clear.
REQ-003 The block SHALL take parameter LIMIT_LO, default 0, as the lowest legal pointer value.
REQ-004 The block SHALL take parameter LIMIT_HI, default 2^W-1, as the highest legal pointer value.
REQ-005 The block SHALL take parameter STEP, default 1, as the increment/decrement magnitude.
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its falling edge.
REQ-007 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-008 The block SHALL have port ctrl, input, 3 bits: operation select, sampled each falling edge.
REQ-009 The block SHALL have port din, input, W bits: load value or signed two's-complement offset.
REQ-010 The block SHALL have port sp, output, W bits: registered stack pointer.
REQ-011 The block SHALL have port ovf, output, 1 bit: sticky overflow flag, registered.
REQ-012 The block SHALL have port udf, output, 1 bit: sticky underflow flag, registered.
REQ-013 The block SHALL have port fault, output, 1 bit: high while in FAULT state.
REQ-014 The block SHALL have port at_lo, output, 1 bit: combinational, sp == LIMIT_LO.
REQ-015 The block SHALL have port at_hi, output, 1 bit: combinational, sp == LIMIT_HI.

Function
REQ-016 The block SHALL check parameters at elaboration: LIMIT_LO <= RESET_VAL <= LIMIT_HI, and 1 <= STEP <= LIMIT_HI-LIMIT_LO; otherwise elaboration fails.
REQ-017 The block SHALL decode ctrl as: 000 hold, 001 clear, 010 inc by STEP, 011 dec by STEP, 100 load din, 101 add signed din, 110/111 reserved and treated as hold.
REQ-018 The block SHALL implement a two-state FSM: RUN and FAULT.
REQ-019 In RUN, the block SHALL compute the candidate value at W+2 bits signed; no wrap-around at any point.
REQ-020 In RUN, when candidate > LIMIT_HI, the block SHALL leave sp unchanged, set ovf, and enter FAULT on the same edge.
REQ-021 In RUN, when candidate < LIMIT_LO, the block SHALL leave sp unchanged, set udf, and enter FAULT on the same edge.
REQ-022 In RUN, when the candidate is in range, the block SHALL take it as sp on the edge: one-cycle latency, visible after that falling edge.
REQ-023 The block SHALL apply the range checks of REQ-020/021 to load (100), with din treated unsigned.
REQ-024 The block SHALL treat din as signed for add (101): din = 2^W-1 means -1.
REQ-025 In FAULT, the block SHALL ignore every ctrl code except clear, and hold sp, ovf and udf.
REQ-026 On clear, in either state, the block SHALL set sp=RESET_VAL, clear ovf and udf, and enter RUN on the same edge.
REQ-027 The block SHALL set ovf and udf only on the transition into FAULT; both can never be high together.
REQ-028 The block SHALL drive fault=1 exactly while the FSM is in FAULT.
REQ-029 The block SHALL drive at_lo and at_hi from registered sp only; they may both be high when LIMIT_LO == LIMIT_HI is impossible per REQ-016.

Reset
REQ-030 The block SHALL, while rst_n=0 and independent of clk, force sp=RESET_VAL, ovf=0, udf=0, and FSM=RUN.
REQ-031 The block SHALL, when rst_n rises, act on the first falling edge that follows.
REQ-032 The block SHALL, on reset mid-operation, abort any pending update; no partial update is visible.

Verification
REQ-033 The bench SHALL cover: reset, then inc x3 -> sp 128,129,130,131; at_lo=at_hi=0.
REQ-034 The bench SHALL cover: load 255, then inc -> sp stays 255, ovf=1, fault=1, at_hi=1; a following dec leaves sp 255 (ignored).
REQ-035 The bench SHALL cover: from FAULT, clear -> sp=128, ovf=0, fault=0 after one falling edge; then dec -> 127.
REQ-036 The bench SHALL cover: sp=2, add din=8'hFD (-3) -> sp stays 2, udf=1; with sp=3, the same add -> sp 0, at_lo=1, no flag.
REQ-037 The bench SHALL cover: instance with STEP=4, LIMIT_HI=130: inc from 128 -> ovf with sp 128; with LIMIT_HI=132 -> sp 132.
REQ-038 The bench SHALL cover: assert rst_n low between edges while in FAULT -> sp=128, flags 0 immediately, no clock needed.
